rv32v_vlsu_seq: RTL and testbench



---
 rtl/rv32i_types_pkg.sv | 12 +
 rtl/rv32v_types_pkg.sv | 28 ++
 rtl/rv32v_vlsu_agu.sv | 39 +++
 rtl/rv32v_vlsu_seq.sv | 177 +++++++++++++++++
 tb/tb_rv32v_vlsu_seq.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types_pkg.sv
// Scalar-core types shared with the load-store controller.
package rv32i_types_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd4,
    LD_HU = 3'd5
  } load_t;

endpackage

// File: rtl/rv32v_types_pkg.sv
// Vector-unit types shared by the load/store sequencer and its AGU.
package rv32v_types_pkg;

  localparam int VLSU_NUM_LANES = 4;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } vsew_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } vlsu_state_t;

  // Vector loads are zero-extended; the VRF sees raw element bits
  function automatic rv32i_types_pkg::load_t eew_load(vsew_t e);
    unique case (e)
      SEW8:    return rv32i_types_pkg::LD_BU;
      SEW16:   return rv32i_types_pkg::LD_HU;
      default: return rv32i_types_pkg::LD_W;
    endcase
  endfunction

endpackage

// File: rtl/rv32v_vlsu_agu.sv
// Per-lane address and enable generation for one beat.
module rv32v_vlsu_agu
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int MAX_VL = 32,
  localparam int BW = (MAX_VL > NUM_LANES) ?
                      $clog2(MAX_VL / NUM_LANES) : 1,
  localparam int EW = $clog2(MAX_VL),
  localparam int VW = EW + 1
)(
  input  logic [31:0]             base,
  input  logic [31:0]             stride,
  input  logic                    strided,
  input  vsew_t                   eew,
  input  logic [BW-1:0]           beat,
  input  logic [VW-1:0]           vl,
  input  logic                    vm,
  input  logic [MAX_VL-1:0]       mask,
  output logic [NUM_LANES*32-1:0] addr,
  output logic [NUM_LANES-1:0]    en
);

  logic [31:0] step;
  logic [31:0] e;

  always_comb begin
    step = strided ? stride : (32'd1 << eew);
    en   = '0;
    addr = '0;
    e    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      e = 32'(beat) * 32'(NUM_LANES) + 32'(i);
      en[i] = (e < 32'(vl)) && (vm || mask[e[EW-1:0]]);
      addr[i*32 +: 32] = base + e * step;
    end
  end

endmodule

// File: rtl/rv32v_vlsu_seq.sv
// Vector load/store sequencer: splits one vector memory op
// into lane-wide LSC beats and returns load data to the VRF.
module rv32v_vlsu_seq
  import rv32v_types_pkg::*;
  import rv32i_types_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int MAX_VL = 32,
  localparam int BW = (MAX_VL > NUM_LANES) ?
                      $clog2(MAX_VL / NUM_LANES) : 1,
  localparam int EW = $clog2(MAX_VL),
  localparam int VW = EW + 1,
  localparam int LW = $clog2(NUM_LANES),
  localparam int DW = NUM_LANES * 32
)(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 is_store,
  input  logic                 strided,
  input  vsew_t                eew,
  input  logic [31:0]          base,
  input  logic [31:0]          stride,
  input  logic [VW-1:0]        vl,
  input  logic                 vm,
  input  logic [MAX_VL-1:0]    mask,
  output logic                 busy,
  output logic [BW-1:0]        beat_idx,
  input  logic [DW-1:0]        vrf_store_data,
  output logic                 lsc_ren,
  output logic                 lsc_wen,
  output logic [NUM_LANES-1:0] lsc_ven_lanes,
  output logic [DW-1:0]        lsc_addr_wide,
  output logic [DW-1:0]        lsc_store_data_wide,
  output load_t                lsc_load_type,
  input  logic                 lsc_ready,
  input  logic                 lsc_mal_addr,
  input  logic [DW-1:0]        lsc_dload_ext_wide,
  output logic                 wb_valid,
  output logic [BW-1:0]        wb_beat,
  output logic [NUM_LANES-1:0] wb_lanes,
  output logic [DW-1:0]        wb_data,
  output logic                 done,
  output logic                 fault,
  output logic [EW-1:0]        fault_elem
);

  vlsu_state_t          state;
  logic [BW-1:0]        beat_q;
  logic [BW-1:0]        last_q;
  logic                 store_q;
  logic                 strided_q;
  vsew_t                eew_q;
  logic [31:0]          base_q;
  logic [31:0]          stride_q;
  logic [VW-1:0]        vl_q;
  logic                 vm_q;
  logic [MAX_VL-1:0]    mask_q;
  load_t                ltype_q;

  logic [DW-1:0]        agu_addr;
  logic [NUM_LANES-1:0] en;
  logic                 req;
  logic                 fire;
  logic                 mal;
  logic                 skip;

  rv32v_vlsu_agu #(
    .NUM_LANES(NUM_LANES),
    .MAX_VL   (MAX_VL)
  ) u_agu (
    .base   (base_q),
    .stride (stride_q),
    .strided(strided_q),
    .eew    (eew_q),
    .beat   (beat_q),
    .vl     (vl_q),
    .vm     (vm_q),
    .mask   (mask_q),
    .addr   (agu_addr),
    .en     (en)
  );

  assign busy = (state == S_ISSUE) || (state == S_WAIT);
  assign req  = ((state == S_ISSUE) && (en != '0)) ||
                (state == S_WAIT);
  assign skip = (state == S_ISSUE) && (en == '0);
  assign mal  = req && lsc_mal_addr;
  assign fire = req && lsc_ready && !lsc_mal_addr;

  assign beat_idx            = beat_q;
  assign lsc_ren             = req && !store_q;
  assign lsc_wen             = req && store_q;
  assign lsc_ven_lanes       = req ? en : '0;
  assign lsc_addr_wide       = req ? agu_addr : '0;
  assign lsc_store_data_wide = lsc_wen ? vrf_store_data : '0;
  assign lsc_load_type       = ltype_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      beat_q     <= '0;
      last_q     <= '0;
      store_q    <= 1'b0;
      strided_q  <= 1'b0;
      eew_q      <= SEW8;
      base_q     <= '0;
      stride_q   <= '0;
      vl_q       <= '0;
      vm_q       <= 1'b0;
      mask_q     <= '0;
      ltype_q    <= LD_B;
      wb_valid   <= 1'b0;
      wb_beat    <= '0;
      wb_lanes   <= '0;
      wb_data    <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_elem <= '0;
    end else begin
      done     <= 1'b0;
      fault    <= 1'b0;
      wb_valid <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start) begin
            store_q    <= is_store;
            strided_q  <= strided;
            eew_q      <= eew;
            base_q     <= base;
            stride_q   <= stride;
            vl_q       <= vl;
            vm_q       <= vm;
            mask_q     <= mask;
            ltype_q    <= eew_load(eew);
            beat_q     <= '0;
            fault_elem <= '0;
            last_q     <= BW'(((32'(vl) +
                          32'(NUM_LANES - 1)) >> LW) - 32'd1);
            if (vl == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          if (mal) begin
            state      <= S_DONE;
            done       <= 1'b1;
            fault      <= 1'b1;
            fault_elem <= EW'(beat_q) << LW;
          end else if (fire || skip) begin
            if (fire && !store_q) begin
              wb_valid <= 1'b1;
              wb_beat  <= beat_q;
              wb_lanes <= en;
              wb_data  <= lsc_dload_ext_wide;
            end
            if (beat_q == last_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              beat_q <= beat_q + BW'(1);
              state  <= S_ISSUE;
            end
          end else begin
            state <= S_WAIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32v_vlsu_seq.sv
// Randomised self-checking bench for the vector load/store sequencer.
module tb_rv32v_vlsu_seq;
  import rv32v_types_pkg::*;
  import rv32i_types_pkg::*;

  localparam int NL  = 4;
  localparam int MVL = 32;
  localparam int DW  = NL * 32;

  logic            CLK = 1'b0;
  logic            RST;
  logic            start, is_store, strided, vm;
  vsew_t           eew;
  logic [31:0]     base, stride;
  logic [5:0]      vl;
  logic [MVL-1:0]  mask;
  logic            busy;
  logic [2:0]      beat_idx;
  logic [DW-1:0]   vrf_store_data;
  logic            lsc_ren, lsc_wen;
  logic [NL-1:0]   lsc_ven_lanes;
  logic [DW-1:0]   lsc_addr_wide, lsc_store_data_wide;
  load_t           lsc_load_type;
  logic            lsc_ready, lsc_mal_addr;
  logic [DW-1:0]   lsc_dload_ext_wide;
  logic            wb_valid;
  logic [2:0]      wb_beat;
  logic [NL-1:0]   wb_lanes;
  logic [DW-1:0]   wb_data;
  logic            done, fault;
  logic [4:0]      fault_elem;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rv32v_vlsu_seq #(.NUM_LANES(NL), .MAX_VL(MVL)) dut (
    .CLK(CLK), .RST(RST), .start(start), .is_store(is_store),
    .strided(strided), .eew(eew), .base(base), .stride(stride),
    .vl(vl), .vm(vm), .mask(mask), .busy(busy),
    .beat_idx(beat_idx), .vrf_store_data(vrf_store_data),
    .lsc_ren(lsc_ren), .lsc_wen(lsc_wen),
    .lsc_ven_lanes(lsc_ven_lanes), .lsc_addr_wide(lsc_addr_wide),
    .lsc_store_data_wide(lsc_store_data_wide),
    .lsc_load_type(lsc_load_type), .lsc_ready(lsc_ready),
    .lsc_mal_addr(lsc_mal_addr),
    .lsc_dload_ext_wide(lsc_dload_ext_wide),
    .wb_valid(wb_valid), .wb_beat(wb_beat), .wb_lanes(wb_lanes),
    .wb_data(wb_data), .done(done), .fault(fault),
    .fault_elem(fault_elem)
  );

  function automatic logic [31:0] vrf_word(int e);
    return 32'h5A00_0000 + 32'(e) * 32'h0001_0203;
  endfunction

  // Stand-in VRF read port: element data is a fixed function of index
  always_comb begin
    vrf_store_data = '0;
    for (int i = 0; i < NL; i++)
      vrf_store_data[i*32 +: 32] = vrf_word(int'(beat_idx) * NL + i);
  end

  // Runs one instruction, predicting every beat from the element rules
  task automatic run_instr(input bit st, input bit sd,
                           input int ew, input logic [31:0] bs,
                           input logic [31:0] sr, input int vln,
                           input bit vmi, input logic [31:0] mk,
                           input int dly, input int malb,
                           input bit poke, input string nm);
    int nb;
    bit faulted;
    bit wb_exp;
    int wb_b;
    logic [NL-1:0] wb_l;
    logic [DW-1:0] wb_d;
    logic [31:0] s;
    logic [NL-1:0] en;
    logic [DW-1:0] ea, esd, dl;
    load_t lt;
    start = 1'b1; is_store = st; strided = sd;
    eew = vsew_t'(2'(ew)); base = bs; stride = sr;
    vl = 6'(vln); vm = vmi; mask = mk;
    @(negedge CLK);
    start = 1'b0;
    base = $urandom; stride = $urandom; vl = 6'($urandom);
    mask = $urandom; vm = 1'($urandom); is_store = 1'($urandom);
    s = sd ? sr : (32'd1 << ew);
    lt = (ew == 0) ? LD_BU : (ew == 1) ? LD_HU : LD_W;
    nb = (vln + NL - 1) / NL;
    faulted = 0; wb_exp = 0;
    wb_b = 0; wb_l = '0; wb_d = '0; dl = '0;
    for (int b = 0; b < nb && !faulted; b++) begin
      en = '0; ea = '0; esd = '0;
      for (int i = 0; i < NL; i++) begin
        int e;
        e = b * NL + i;
        en[i] = (e < vln) && (vmi || mk[e]);
        ea[i*32 +: 32] = bs + 32'(e) * s;
        esd[i*32 +: 32] = vrf_word(e);
      end
      if (en == '0) begin
        checks++;
        if (lsc_ren !== 1'b0 || lsc_wen !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s skip b%0d: ren %b wen %b busy %b want 0 0 1",
                   nm, b, lsc_ren, lsc_wen, busy);
        end
        checks++;
        if (wb_valid !== wb_exp ||
            (wb_exp && (wb_beat !== 3'(wb_b) || wb_lanes !== wb_l ||
                        wb_data !== wb_d))) begin
          errors++;
          $display("FAIL %s wb@skip b%0d: valid %b beat %0d lanes %b want %b %0d %b",
                   nm, b, wb_valid, wb_beat, wb_lanes, wb_exp, wb_b, wb_l);
        end
        wb_exp = 0;
        @(negedge CLK);
      end else begin
        for (int w = 0; w <= dly; w++) begin
          checks++;
          if (lsc_ren !== !st || lsc_wen !== st || busy !== 1'b1 ||
              beat_idx !== 3'(b)) begin
            errors++;
            $display("FAIL %s req b%0d w%0d: ren %b wen %b busy %b beat %0d",
                     nm, b, w, lsc_ren, lsc_wen, busy, beat_idx);
          end
          checks++;
          if (lsc_ven_lanes !== en || lsc_addr_wide !== ea) begin
            errors++;
            $display("FAIL %s addr b%0d w%0d: ven %b addr %h want %b %h",
                     nm, b, w, lsc_ven_lanes, lsc_addr_wide, en, ea);
          end
          checks++;
          if (st ? (lsc_store_data_wide !== esd)
                 : (lsc_load_type !== lt)) begin
            errors++;
            $display("FAIL %s data b%0d: sd %h lt %0d want %h %0d",
                     nm, b, lsc_store_data_wide, lsc_load_type, esd, lt);
          end
          checks++;
          if (wb_valid !== wb_exp ||
              (wb_exp && (wb_beat !== 3'(wb_b) || wb_lanes !== wb_l ||
                          wb_data !== wb_d))) begin
            errors++;
            $display("FAIL %s wb@req b%0d: valid %b beat %0d lanes %b want %b %0d %b",
                     nm, b, wb_valid, wb_beat, wb_lanes, wb_exp, wb_b, wb_l);
          end
          wb_exp = 0;
          if (poke && w < dly) begin
            start = 1'b1; base = $urandom; vl = 6'($urandom_range(1, 32));
          end else begin
            start = 1'b0;
          end
          if (w == dly) begin
            lsc_ready = 1'b1;
            lsc_mal_addr = (b == malb);
            for (int i = 0; i < NL; i++) dl[i*32 +: 32] = $urandom;
            lsc_dload_ext_wide = dl;
          end
          @(negedge CLK);
          start = 1'b0; lsc_ready = 1'b0; lsc_mal_addr = 1'b0;
        end
        if (b == malb) begin
          faulted = 1;
          checks++;
          if (done !== 1'b1 || fault !== 1'b1 || busy !== 1'b0 ||
              fault_elem !== 5'(b * NL) || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s fault: done %b fault %b busy %b elem %0d wb %b want 1 1 0 %0d 0",
                     nm, done, fault, busy, fault_elem, wb_valid, b * NL);
          end
        end else if (!st) begin
          wb_exp = 1; wb_b = b; wb_l = en; wb_d = dl;
        end
      end
    end
    if (!faulted) begin
      checks++;
      if (done !== 1'b1 || fault !== 1'b0 || busy !== 1'b0 ||
          lsc_ren !== 1'b0 || lsc_wen !== 1'b0) begin
        errors++;
        $display("FAIL %s done: done %b fault %b busy %b ren %b wen %b want 1 0 0 0 0",
                 nm, done, fault, busy, lsc_ren, lsc_wen);
      end
      checks++;
      if (wb_valid !== wb_exp ||
          (wb_exp && (wb_beat !== 3'(wb_b) || wb_lanes !== wb_l ||
                      wb_data !== wb_d))) begin
        errors++;
        $display("FAIL %s wb@done: valid %b beat %0d lanes %b want %b %0d %b",
                 nm, wb_valid, wb_beat, wb_lanes, wb_exp, wb_b, wb_l);
      end
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || fault !== 1'b0 || busy !== 1'b0 ||
        wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: done %b fault %b busy %b wb %b want 0 0 0 0",
               nm, done, fault, busy, wb_valid);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({busy, lsc_ren, lsc_wen, wb_valid, done, fault} !== 6'b0) begin
      errors++;
      $display("FAIL reset ctl: %b want 000000",
               {busy, lsc_ren, lsc_wen, wb_valid, done, fault});
    end
    checks++;
    if (lsc_ven_lanes !== '0 || lsc_addr_wide !== '0 ||
        lsc_store_data_wide !== '0 || wb_data !== '0 ||
        wb_lanes !== '0 || beat_idx !== '0 || wb_beat !== '0 ||
        fault_elem !== '0 || lsc_load_type !== LD_B) begin
      errors++;
      $display("FAIL reset vec: ven %b addr %h beat %0d elem %0d lt %0d want 0",
               lsc_ven_lanes, lsc_addr_wide, beat_idx, fault_elem,
               lsc_load_type);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_unit_load();
    run_instr(0, 0, 2, 32'h1000, 0, 8, 1, 0, 0, -1, 0, "unit_load");
  endtask

  task automatic test_strided_store();
    run_instr(1, 1, 2, 32'h2000, 32'hFFFF_FFF8, 3, 1, 0, 3, -1, 0,
              "strided_store");
  endtask

  task automatic test_mask_skip();
    run_instr(0, 0, 2, 32'h3000, 0, 8, 0, 32'h0F, 0, -1, 0, "mask_skip");
  endtask

  task automatic test_misaligned();
    run_instr(0, 0, 2, 32'h4002, 0, 8, 1, 0, 1, 1, 0, "misaligned");
  endtask

  task automatic test_vl_zero();
    run_instr(0, 0, 1, 32'h5000, 0, 0, 1, 0, 0, -1, 0, "vl_zero");
  endtask

  task automatic test_stride_wrap();
    run_instr(0, 1, 2, 32'hFFFF_FFF0, 32'h10, 2, 1, 0, 0, -1, 0,
              "stride_wrap");
  endtask

  task automatic test_start_busy();
    run_instr(1, 0, 0, 32'h6001, 0, 6, 1, 0, 4, -1, 1, "start_busy");
  endtask

  task automatic test_reset_mid();
    start = 1'b1; is_store = 1'b0; strided = 1'b0; eew = SEW32;
    base = 32'h7000; vl = 6'd8; vm = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || lsc_ren !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy %b ren %b done %b want 0 0 0",
               busy, lsc_ren, done);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lsc_ren !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid after: busy %b done %b ren %b want 0 0 0",
               busy, done, lsc_ren);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int vln, malb;
      vln = $urandom_range(0, MVL);
      malb = ($urandom_range(0, 3) == 0) ?
             $urandom_range(0, (vln > 0) ? (vln - 1) / NL : 0) : -1;
      run_instr(1'($urandom), 1'($urandom), $urandom_range(0, 2),
                $urandom, $urandom, vln, 1'($urandom), $urandom,
                $urandom_range(0, 3), malb, 1'($urandom), "random");
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; is_store = 1'b0; strided = 1'b0;
    eew = SEW8; base = '0; stride = '0; vl = '0; vm = 1'b0;
    mask = '0; lsc_ready = 1'b0; lsc_mal_addr = 1'b0;
    lsc_dload_ext_wide = '0;
    @(negedge CLK);
    test_reset();
    test_unit_load();
    test_strided_store();
    test_mask_skip();
    test_misaligned();
    test_vl_zero();
    test_stride_wrap();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
